regfile_bypass: RTL and testbench

- Parametrised successor of the pipeline's general-purpose register file.
- Width and depth are set by parameters, and register 0 can be made a hardwired zero.
- Writes commit on the rising edge; a same-cycle write is forwarded combinationally to both read ports.
- A sequential clear engine zeroes every entry after reset and reports busy while it runs.
- Sits in ID, fed by the WB stage.

---
 rtl/regfile_bypass_if.sv | 35 +++
 rtl/regfile_bypass.sv | 114 +++++++++++
 tb/tb_regfile_bypass.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_bypass_if.sv
// ---------------------------------------------------------------------------
// regfile_bypass_if
// Bus between the WB/ID pipeline logic and the register file.
//   RegWrite  : write enable from WB
//   rd        : write address
//   WriteData : write data
//   rs, rt    : read addresses for ports 1 and 2
//   readdata1 : data at rs (combinational, write-first bypassed)
//   readdata2 : data at rt (combinational, write-first bypassed)
//   busy      : clear engine running; writes ignored, reads return 0
// master = pipeline side, slave = register file side.
// ---------------------------------------------------------------------------
interface regfile_bypass_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] rd;
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [WIDTH-1:0]  readdata1;
  logic [WIDTH-1:0]  readdata2;
  logic              busy;

  modport master (
    output RegWrite, rd, WriteData, rs, rt,
    input  readdata1, readdata2, busy
  );

  modport slave (
    input  RegWrite, rd, WriteData, rs, rt,
    output readdata1, readdata2, busy
  );
endinterface

// File: rtl/regfile_bypass.sv
// ---------------------------------------------------------------------------
// regfile_bypass
// Parametrised general-purpose register file for the ID stage, written from
// WB. Two combinational read ports with write-first forwarding of a
// same-cycle write. Optional hardwired zero in entry 0. After every reset a
// sequential clear engine zeroes one entry per clock and holds busy high.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset, restarts the clear engine
//   bus : regfile_bypass_if.slave (write port, two read ports, busy)
// ---------------------------------------------------------------------------
module regfile_bypass #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  regfile_bypass_if.slave    bus
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam bit              ZR       = (ZERO_REG != 0);
  // Counter is one bit wider than the address so the terminal value is
  // distinguishable from a wrapped zero.
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic              w_busy;
  logic              w_we;
  logic [WIDTH-1:0]  w_rdata1;
  logic [WIDTH-1:0]  w_rdata2;

  // One read port: busy masks everything, then the hardwired zero, then the
  // same-cycle write wins over the stored value.
  function automatic logic [WIDTH-1:0] read_port(
    input logic              busy,
    input logic [ADDR_W-1:0] raddr,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [WIDTH-1:0]  wdata,
    input logic [WIDTH-1:0]  stored
  );
    logic [WIDTH-1:0] v;
    v = stored;
    if (busy)                         v = '0;
    else if (ZR && (raddr == '0))     v = '0;
    else if (we && (waddr == raddr))  v = wdata;
    return v;
  endfunction

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        if (r_cnt == CNT_LAST) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  assign w_busy = (r_state == ST_CLEAR);
  // A write to the hardwired zero is dropped here, so it neither commits
  // nor forwards.
  assign w_we   = bus.RegWrite && !w_busy && !(ZR && (bus.rd == '0));

  // Storage: clear engine owns the array while busy
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) r_mem[r_cnt[ADDR_W-1:0]] <= '0;
      else if (w_we)           r_mem[bus.rd]            <= bus.WriteData;
    end
  end

  // Read ports
  always_comb begin
    w_rdata1 = read_port(w_busy, bus.rs, w_we, bus.rd, bus.WriteData, r_mem[bus.rs]);
    w_rdata2 = read_port(w_busy, bus.rt, w_we, bus.rd, bus.WriteData, r_mem[bus.rt]);
  end

  assign bus.readdata1 = w_rdata1;
  assign bus.readdata2 = w_rdata2;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_regfile_bypass.sv
module tb_regfile_bypass;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  regfile_bypass_if #(.WIDTH(32), .ADDR_W(5)) if0 ();
  regfile_bypass_if #(.WIDTH(32), .ADDR_W(5)) if1 ();
  regfile_bypass_if #(.WIDTH(16), .ADDR_W(3)) if2 ();

  regfile_bypass #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1))
    u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  regfile_bypass #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(0))
    u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  regfile_bypass #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .ZERO_REG(1))
    u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count rising edges until each instance drops busy; also checks that
  // port 1 of u0 reads 0 throughout the clear with rs sweeping, and
  // optionally issues a write to rd=20 while the counter sits at 3.
  task automatic run_clear(input string tag, input bit inject_write,
                           output int t0, output int t1, output int t2);
    int rd1_err;
    rd1_err = 0;
    t0 = 0; t1 = 0; t2 = 0;
    for (int n = 0; n < 100; n++) begin
      if (inject_write && n == 3) begin
        if0.RegWrite = 1'b1; if0.rd = 5'd20; if0.WriteData = 32'h55;
      end else begin
        if0.RegWrite = 1'b0;
      end
      if0.rs = 5'(n + 1);
      #1;
      if (if0.busy === 1'b1 && if0.readdata1 !== 32'h0) rd1_err++;
      step();
      if (t0 == 0 && if0.busy === 1'b0) t0 = n + 1;
      if (t1 == 0 && if1.busy === 1'b0) t1 = n + 1;
      if (t2 == 0 && if2.busy === 1'b0) t2 = n + 1;
      if (t0 != 0 && t1 != 0 && t2 != 0) break;
    end
    if0.RegWrite = 1'b0;
    chk({tag, "_rd1_zero_while_busy"}, 32'(rd1_err), 32'd0);
  endtask

  initial begin
    int t0, t1, t2, errs;
    total = 0;
    bad   = 0;

    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd6,  5'd0,  32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 5'd7,  32'hAAAAAAAA, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hAAAAAAAA, 32'hAAAAAAAA};
    vecs[4]  = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  32'h12345678, 32'h12345678};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h12345678, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'h12345678};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[8]  = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd7,  32'hCAFEF00D, 32'h12345678};
    vecs[10] = '{1'b1, 5'd3,  32'h00000011, 5'd7,  5'd3,  32'h12345678, 32'h00000011};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd31, 32'h00000011, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 5'd3,  32'h00000099, 5'd3,  5'd3,  32'h00000011, 32'h00000011};

    if0.RegWrite = 1'b0; if0.rd = '0; if0.WriteData = '0; if0.rs = '0; if0.rt = '0;
    if1.RegWrite = 1'b0; if1.rd = '0; if1.WriteData = '0; if1.rs = '0; if1.rt = '0;
    if2.RegWrite = 1'b0; if2.rd = '0; if2.WriteData = '0; if2.rs = '0; if2.rt = '0;

    // Reset, with a write attempt at counter 3 during the clear
    rst = 1'b1;
    step();
    chk("rst_busy_u0", 32'(if0.busy), 32'd1);
    chk("rst_busy_u2", 32'(if2.busy), 32'd1);
    chk("rst_rd1_u0", if0.readdata1, 32'h0);
    chk("rst_rd2_u0", if0.readdata2, 32'h0);
    rst = 1'b0;
    run_clear("clr", 1'b1, t0, t1, t2);
    chk("clr_edges_u0", 32'(t0), 32'd32);
    chk("clr_edges_u1", 32'(t1), 32'd32);
    chk("clr_edges_u2", 32'(t2), 32'd8);

    // Every entry reads zero after the clear, including rd=20
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      if0.rs = 5'(i); if0.rt = 5'(31 - i);
      #1;
      if (if0.readdata1 !== 32'h0 || if0.readdata2 !== 32'h0) errs++;
    end
    chk("clr_all_zero", 32'(errs), 32'd0);
    if0.rs = 5'd20; #1;
    chk("clr_write_ignored_e20", if0.readdata1, 32'h0);

    // Table-driven writes, reads and bypasses on the default instance
    for (int i = 0; i < 13; i++) begin
      if0.RegWrite = vecs[i].we; if0.rd = vecs[i].rd; if0.WriteData = vecs[i].wdata;
      if0.rs = vecs[i].rs; if0.rt = vecs[i].rt;
      #1;
      chk($sformatf("vec%0d_rd1", i), if0.readdata1, vecs[i].exp1);
      chk($sformatf("vec%0d_rd2", i), if0.readdata2, vecs[i].exp2);
      step();
    end
    if0.RegWrite = 1'b0;

    // Entry 0 as an ordinary register
    if1.RegWrite = 1'b1; if1.rd = 5'd0; if1.WriteData = 32'hFFFFFFFF;
    if1.rs = 5'd0; if1.rt = 5'd1;
    #1;
    chk("nz_bypass_rd1", if1.readdata1, 32'hFFFFFFFF);
    chk("nz_bypass_rd2", if1.readdata2, 32'h0);
    step();
    if1.RegWrite = 1'b0;
    #1;
    chk("nz_stored_rd1", if1.readdata1, 32'hFFFFFFFF);

    // Small configuration: 8 x 16
    if2.RegWrite = 1'b1; if2.rd = 3'd7; if2.WriteData = 16'hBEEF;
    if2.rs = 3'd7; if2.rt = 3'd6;
    #1;
    chk("s_bypass_rd1", 32'(if2.readdata1), 32'h0000BEEF);
    chk("s_bypass_rd2", 32'(if2.readdata2), 32'h0);
    step();
    if2.RegWrite = 1'b1; if2.rd = 3'd0; if2.WriteData = 16'h1234;
    if2.rs = 3'd7; if2.rt = 3'd0;
    #1;
    chk("s_stored_rd1", 32'(if2.readdata1), 32'h0000BEEF);
    chk("s_zero_rd2", 32'(if2.readdata2), 32'h0);
    step();
    if2.RegWrite = 1'b0;
    #1;
    chk("s_zero_after", 32'(if2.readdata2), 32'h0);

    // Reset mid-clear: restart at counter 10
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 10; n++) step();
    chk("mid_busy_before", 32'(if0.busy), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_busy_at_rst", 32'(if0.busy), 32'd1);
    rst = 1'b0;
    run_clear("mid", 1'b0, t0, t1, t2);
    chk("mid_edges_u0", 32'(t0), 32'd32);
    chk("mid_edges_u2", 32'(t2), 32'd8);
    if0.rs = 5'd7; if0.rt = 5'd31;
    if2.rs = 3'd7;
    #1;
    chk("mid_cleared_e7", if0.readdata1, 32'h0);
    chk("mid_cleared_e31", if0.readdata2, 32'h0);
    chk("mid_cleared_s7", 32'(if2.readdata1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
